// File: rtl/tablero_pkg.sv
// Shared types and constants for the N x N board video generator.
// Cell/state encodings, result codes and the RGB palette used by the renderer.
package tablero_pkg;

  typedef enum logic [1:0] {
    VACIA = 2'd0,
    JUG1  = 2'd1,
    JUG2  = 2'd2
  } celda_t;

  typedef enum logic [1:0] {
    JUGANDO   = 2'd0,
    VERIFICAR = 2'd1,
    FIN       = 2'd2
  } estado_t;

  localparam logic [1:0] GANO_NADIE  = 2'd0;
  localparam logic [1:0] GANO_J1     = 2'd1;
  localparam logic [1:0] GANO_J2     = 2'd2;
  localparam logic [1:0] GANO_EMPATE = 2'd3;

  localparam logic [23:0] C_NEGRO    = 24'h000000;
  localparam logic [23:0] C_BLANCO   = 24'hFFFFFF;
  localparam logic [23:0] C_AMARILLO = 24'hFFFF00;
  localparam logic [23:0] C_ROJO     = 24'hFF0000;
  localparam logic [23:0] C_AZUL     = 24'h0000FF;
  localparam logic [23:0] C_ROJO_MED = 24'h7F0000;
  localparam logic [23:0] C_AZUL_MED = 24'h00007F;
  localparam logic [23:0] C_ROJO_CUA = 24'h3F0000;
  localparam logic [23:0] C_AZUL_CUA = 24'h00003F;
  localparam logic [23:0] C_GRIS     = 24'h404040;

endpackage

// File: rtl/tablero_video_nxn_if.sv
// Pixel-position, button and board/colour bundle between the VGA timing block and the game.
// The master side drives counters and buttons; the slave side (the game) returns board and RGB.
interface tablero_video_nxn_if #(parameter int N = 3);
  logic             frame_tick;
  logic [9:0]       cuentaX;
  logic [9:0]       cuentaY;
  logic             boton;
  logic             boton2;
  logic             boton3;
  logic [2*N*N-1:0] celdas;
  logic             turno;
  logic [1:0]       gano;
  logic             output_gano;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;

  modport master (
    output frame_tick, cuentaX, cuentaY, boton, boton2, boton3,
    input  celdas, turno, gano, output_gano, r, g, b
  );

  modport slave (
    input  frame_tick, cuentaX, cuentaY, boton, boton2, boton3,
    output celdas, turno, gano, output_gano, r, g, b
  );
endinterface

// File: rtl/tablero_video_nxn_antirrebote.sv
// Button conditioner: 2-flop synchroniser, frame-sampled debounce, one-cycle rising-edge pulse.
module antirrebote #(
  parameter int DEB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic boton_in,
  output logic pulso
);

  localparam int CNT_W = (DEB_FRAMES < 2) ? 1 : $clog2(DEB_FRAMES + 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             estable_q, estable_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d      = boton_in;
    s2_d      = s1_q;
    prev_d    = estable_q;
    estable_d = estable_q;
    cnt_d     = cnt_q;
    // Any sample that agrees with the accepted level restarts the run count.
    if (frame_tick) begin
      if (s2_q == estable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_FRAMES - 1)) begin
        estable_d = s2_q;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      estable_q <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      estable_q <= estable_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pulso = estable_q & ~prev_q;

endmodule

// File: rtl/tablero_video_nxn.sv
// N x N two-player board game with cursor, win/draw detection and a registered 24-bit pixel renderer.
module tablero_video_nxn
  import tablero_pkg::*;
#(
  parameter int N          = 3,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int LINE_W     = 8,
  parameter int DEB_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  tablero_video_nxn_if.slave   bus
);

  localparam int NN    = N * N;
  localparam int CUR_W = $clog2(NN);
  localparam int CW    = H_RES / N;
  localparam int CH    = V_RES / N;
  localparam int HALF  = LINE_W / 2;

  logic ev_mover, ev_marcar, ev_nuevo;

  antirrebote #(.DEB_FRAMES(DEB_FRAMES)) u_mover (
    .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .boton_in(bus.boton), .pulso(ev_mover)
  );
  antirrebote #(.DEB_FRAMES(DEB_FRAMES)) u_marcar (
    .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .boton_in(bus.boton2), .pulso(ev_marcar)
  );
  antirrebote #(.DEB_FRAMES(DEB_FRAMES)) u_nuevo (
    .clk(clk), .rst(rst), .frame_tick(bus.frame_tick), .boton_in(bus.boton3), .pulso(ev_nuevo)
  );

  estado_t          estado_q, estado_d;
  logic [CUR_W-1:0] cursor_q, cursor_d;
  logic             turno_q, turno_d;
  logic [1:0]       gano_q, gano_d;
  celda_t           celdas_q [NN];
  celda_t           celdas_d [NN];
  logic [23:0]      rgb_q, rgb_d;

  // Line detection: rows and columns per generate slice, diagonals and fullness below.
  logic [N-1:0] fila_ok, col_ok;
  logic         diag0_ok, diag1_ok, lleno, hay_linea;

  for (genvar i = 0; i < N; i++) begin : g_linea
    logic f_ok, c_ok;
    always_comb begin
      f_ok = (celdas_q[i*N] != VACIA);
      c_ok = (celdas_q[i] != VACIA);
      for (int k = 1; k < N; k++) begin
        if (celdas_q[i*N + k] != celdas_q[i*N]) f_ok = 1'b0;
        if (celdas_q[k*N + i] != celdas_q[i])   c_ok = 1'b0;
      end
    end
    assign fila_ok[i] = f_ok;
    assign col_ok[i]  = c_ok;
  end

  always_comb begin
    diag0_ok = (celdas_q[0] != VACIA);
    diag1_ok = (celdas_q[N-1] != VACIA);
    lleno    = 1'b1;
    for (int k = 1; k < N; k++) begin
      if (celdas_q[k*N + k] != celdas_q[0])           diag0_ok = 1'b0;
      if (celdas_q[k*N + N-1-k] != celdas_q[N-1])     diag1_ok = 1'b0;
    end
    for (int i = 0; i < NN; i++) begin
      if (celdas_q[i] == VACIA) lleno = 1'b0;
    end
  end

  assign hay_linea = (|fila_ok) | (|col_ok) | diag0_ok | diag1_ok;

  // Only the player who just moved can have completed a line, so turno names the winner.
  always_comb begin
    estado_d = estado_q;
    cursor_d = cursor_q;
    turno_d  = turno_q;
    gano_d   = gano_q;
    celdas_d = celdas_q;
    if (ev_nuevo) begin
      estado_d = JUGANDO;
      cursor_d = '0;
      turno_d  = 1'b0;
      gano_d   = GANO_NADIE;
      for (int i = 0; i < NN; i++) celdas_d[i] = VACIA;
    end else begin
      case (estado_q)
        JUGANDO: begin
          if (ev_marcar && celdas_q[cursor_q] == VACIA) begin
            celdas_d[cursor_q] = turno_q ? JUG2 : JUG1;
            estado_d           = VERIFICAR;
          end
          if (ev_mover) begin
            cursor_d = (cursor_q == CUR_W'(NN - 1)) ? '0 : cursor_q + 1'b1;
          end
        end
        VERIFICAR: begin
          if (hay_linea) begin
            gano_d   = turno_q ? GANO_J2 : GANO_J1;
            estado_d = FIN;
          end else if (lleno) begin
            gano_d   = GANO_EMPATE;
            estado_d = FIN;
          end else begin
            turno_d  = ~turno_q;
            estado_d = JUGANDO;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel-to-cell mapping against the N-1 internal boundaries.
  logic [N-2:0] x_ge, y_ge, x_lin, y_lin;

  for (genvar k = 1; k < N; k++) begin : g_borde
    assign x_ge[k-1]  = int'(bus.cuentaX) >= k*CW;
    assign y_ge[k-1]  = int'(bus.cuentaY) >= k*CH;
    assign x_lin[k-1] = (int'(bus.cuentaX) + HALF >= k*CW) && (int'(bus.cuentaX) < k*CW + HALF);
    assign y_lin[k-1] = (int'(bus.cuentaY) + HALF >= k*CH) && (int'(bus.cuentaY) < k*CH + HALF);
  end

  int               col_i, fila_i;
  logic [CUR_W-1:0] idx_pix;
  celda_t           c_pix;
  logic             fuera;

  always_comb begin
    col_i  = 0;
    fila_i = 0;
    for (int k = 0; k < N-1; k++) begin
      if (x_ge[k]) col_i  = k + 1;
      if (y_ge[k]) fila_i = k + 1;
    end
    idx_pix = CUR_W'(fila_i * N + col_i);
    c_pix   = celdas_q[idx_pix];
    fuera   = (int'(bus.cuentaX) >= H_RES) || (int'(bus.cuentaY) >= V_RES) ||
              (int'(bus.cuentaX) >= N*CW)  || (int'(bus.cuentaY) >= N*CH);
    rgb_d   = C_NEGRO;
    if (fuera) begin
      rgb_d = C_NEGRO;
    end else if ((|x_lin) || (|y_lin)) begin
      rgb_d = C_BLANCO;
    end else if (estado_q == JUGANDO && idx_pix == cursor_q) begin
      rgb_d = (c_pix == VACIA) ? C_AMARILLO : (c_pix == JUG1) ? C_ROJO_MED : C_AZUL_MED;
    end else if (c_pix == JUG1) begin
      rgb_d = C_ROJO;
    end else if (c_pix == JUG2) begin
      rgb_d = C_AZUL;
    end else if (estado_q == FIN) begin
      case (gano_q)
        GANO_J1:     rgb_d = C_ROJO_CUA;
        GANO_J2:     rgb_d = C_AZUL_CUA;
        GANO_EMPATE: rgb_d = C_GRIS;
        default:     rgb_d = C_NEGRO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= JUGANDO;
      cursor_q <= '0;
      turno_q  <= 1'b0;
      gano_q   <= GANO_NADIE;
      rgb_q    <= '0;
      for (int i = 0; i < NN; i++) celdas_q[i] <= VACIA;
    end else begin
      estado_q <= estado_d;
      cursor_q <= cursor_d;
      turno_q  <= turno_d;
      gano_q   <= gano_d;
      rgb_q    <= rgb_d;
      for (int i = 0; i < NN; i++) celdas_q[i] <= celdas_d[i];
    end
  end

  for (genvar i = 0; i < NN; i++) begin : g_celdas
    assign bus.celdas[2*i +: 2] = celdas_q[i];
  end

  assign bus.turno       = turno_q;
  assign bus.gano        = gano_q;
  assign bus.output_gano = (gano_q != GANO_NADIE);
  assign bus.r           = rgb_q[23:16];
  assign bus.g           = rgb_q[15:8];
  assign bus.b           = rgb_q[7:0];

endmodule

// File: tb/tb_tablero_video_nxn.sv
// Directed bench: a 3x3 and a 4x4 instance share clock, reset, frame tick and pixel counters;
// buttons are steered to one instance by sel.
module tb_tablero_video_nxn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       sel = 1'b0;
  logic       boton = 1'b0, boton2 = 1'b0, boton3 = 1'b0;
  logic [9:0] cx = 10'd700, cy = 10'd0;

  int errors = 0;
  int checks = 0;
  int cur3 = 0, cur4 = 0;

  always #5 clk = ~clk;

  tablero_video_nxn_if #(.N(3)) if3 ();
  tablero_video_nxn_if #(.N(4)) if4 ();

  assign if3.frame_tick = frame_tick;
  assign if3.cuentaX    = cx;
  assign if3.cuentaY    = cy;
  assign if3.boton      = boton  & ~sel;
  assign if3.boton2     = boton2 & ~sel;
  assign if3.boton3     = boton3 & ~sel;
  assign if4.frame_tick = frame_tick;
  assign if4.cuentaX    = cx;
  assign if4.cuentaY    = cy;
  assign if4.boton      = boton  & sel;
  assign if4.boton2     = boton2 & sel;
  assign if4.boton3     = boton3 & sel;

  tablero_video_nxn #(.N(3), .H_RES(640), .V_RES(480), .LINE_W(8), .DEB_FRAMES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );
  tablero_video_nxn #(.N(4), .H_RES(640), .V_RES(480), .LINE_W(8), .DEB_FRAMES(3)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // Hold the masked buttons {boton3,boton2,boton} for n frame ticks, then release cleanly.
  task automatic pulsar(input logic [2:0] m, input int n);
    {boton3, boton2, boton} = m;
    repeat (n) frame_pulse();
    repeat (4) @(posedge clk);
    #1 {boton3, boton2, boton} = 3'b000;
    repeat (3) frame_pulse();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic mover();
    pulsar(3'b001, 3);
    if (sel) cur4 = (cur4 + 1) % 16;
    else     cur3 = (cur3 + 1) % 9;
  endtask

  task automatic ir_a(input int t);
    if (sel) while (cur4 != t) mover();
    else     while (cur3 != t) mover();
  endtask

  task automatic marcar(input int t);
    ir_a(t);
    pulsar(3'b010, 3);
  endtask

  task automatic nuevo();
    pulsar(3'b100, 3);
    if (sel) cur4 = 0;
    else     cur3 = 0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk);
    #1 chk(tag, {8'h0, if3.r, if3.g, if3.b}, {8'h0, exp});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_celdas3", 32'(if3.celdas), 32'h0);
    chk("rst_turno3", 32'(if3.turno), 32'h0);
    chk("rst_gano3", 32'(if3.gano), 32'h0);
    chk("rst_og3", 32'(if3.output_gano), 32'h0);
    chk("rst_rgb3", {8'h0, if3.r, if3.g, if3.b}, 32'h0);
    chk("rst_celdas4", if4.celdas, 32'h0);
    chk("rst_gano4", 32'(if4.gano), 32'h0);

    // Cursor starts on cell 0; one debounced press moves it to cell 1, a short press does not.
    pix("cursor0", 100, 80, 24'hFFFF00);
    mover();
    pix("cursor1", 320, 80, 24'hFFFF00);
    pix("cell0_after_move", 100, 80, 24'h000000);
    pulsar(3'b001, 2);
    pix("short_press_cursor1", 320, 80, 24'hFFFF00);

    // Player 1 wins along the top row.
    marcar(0); marcar(3); marcar(1); marcar(4);
    chk("win_pre_gano", 32'(if3.gano), 32'h0);
    marcar(2);
    chk("win_celdas", 32'(if3.celdas), 32'h295);
    chk("win_gano", 32'(if3.gano), 32'h1);
    chk("win_og", 32'(if3.output_gano), 32'h1);
    chk("win_turno", 32'(if3.turno), 32'h0);
    pulsar(3'b001, 3);
    pulsar(3'b010, 3);
    pulsar(3'b011, 3);
    chk("fin_frozen_celdas", 32'(if3.celdas), 32'h295);
    chk("fin_frozen_gano", 32'(if3.gano), 32'h1);
    pix("fin_empty_quarter", 533, 240, 24'h3F0000);
    pix("fin_p1_cell", 533, 80, 24'hFF0000);
    pix("grid_line", 213, 50, 24'hFFFFFF);
    pix("offscreen", 700, 50, 24'h000000);

    // New game together with a mark: clear wins.
    pulsar(3'b110, 3);
    cur3 = 0;
    chk("new_celdas", 32'(if3.celdas), 32'h0);
    chk("new_gano", 32'(if3.gano), 32'h0);
    chk("new_og", 32'(if3.output_gano), 32'h0);
    chk("new_turno", 32'(if3.turno), 32'h0);
    pix("new_cursor0", 100, 80, 24'hFFFF00);

    // Marking an occupied cell is ignored.
    marcar(0);
    chk("occ_pre_celdas", 32'(if3.celdas), 32'h1);
    chk("occ_pre_turno", 32'(if3.turno), 32'h1);
    pulsar(3'b010, 3);
    chk("occ_celdas", 32'(if3.celdas), 32'h1);
    chk("occ_turno", 32'(if3.turno), 32'h1);
    pix("cursor_on_p1", 100, 80, 24'h7F0000);

    // Draw.
    nuevo();
    marcar(0); marcar(1); marcar(2); marcar(4);
    marcar(3); marcar(5); marcar(7); marcar(6);
    chk("draw_pre_gano", 32'(if3.gano), 32'h0);
    marcar(8);
    chk("draw_gano", 32'(if3.gano), 32'h3);
    chk("draw_celdas", 32'(if3.celdas), 32'h16A59);
    chk("draw_cell8", 32'(if3.celdas[17:16]), 32'h1);
    chk("draw_turno", 32'(if3.turno), 32'h0);
    pix("draw_cell8_pix", 533, 400, 24'hFF0000);

    // 4x4: player 2 takes the main diagonal.
    sel = 1'b1;
    marcar(1); marcar(5); marcar(2); marcar(10);
    marcar(3); marcar(15); marcar(4);
    chk("n4_pre_gano", 32'(if4.gano), 32'h0);
    chk("n4_pre_turno", 32'(if4.turno), 32'h1);
    marcar(0);
    chk("n4_gano", 32'(if4.gano), 32'h2);
    chk("n4_og", 32'(if4.output_gano), 32'h1);
    chk("n4_celdas", if4.celdas, 32'h80200956);
    chk("n4_celdas3_untouched", 32'(if3.celdas), 32'h16A59);
    sel = 1'b0;

    // Asynchronous reset in the middle of a game.
    nuevo();
    marcar(0);
    pix("pre_rst_rgb", 100, 80, 24'h7F0000);
    chk("pre_rst_turno", 32'(if3.turno), 32'h1);
    rst = 1'b1;
    #2;
    chk("arst_celdas3", 32'(if3.celdas), 32'h0);
    chk("arst_turno3", 32'(if3.turno), 32'h0);
    chk("arst_gano3", 32'(if3.gano), 32'h0);
    chk("arst_og3", 32'(if3.output_gano), 32'h0);
    chk("arst_rgb3", {8'h0, if3.r, if3.g, if3.b}, 32'h0);
    chk("arst_gano4", 32'(if4.gano), 32'h0);
    chk("arst_og4", 32'(if4.output_gano), 32'h0);
    chk("arst_celdas4", if4.celdas, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
